// File: rtl/analog_apb_pkg.sv
// ----------------------------------------------------------------------------
// analog_apb_pkg
// Shared types and defaults for the analog-subsystem APB initiator.
//   apb_state_e     : initiator FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb_rsp_flags_t : status half of the held response (err, timeout)
//   APB_ADDR_WIDTH  : default APB address width
//   APB_DATA_WIDTH  : default APB data width
// ----------------------------------------------------------------------------
package analog_apb_pkg;

  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // The read data lives beside this struct in the top, because its width
  // follows the top's DATA_WIDTH parameter.
  typedef struct packed {
    logic err;
    logic timeout;
  } apb_rsp_flags_t;

endpackage

// File: rtl/analog_apb_timeout_cnt.sv
// ----------------------------------------------------------------------------
// analog_apb_timeout_cnt
// Watchdog counter for the APB ACCESS phase.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   clear           : zero the count (held while the initiator is in SETUP)
//   enable          : one ACCESS cycle without PREADY has elapsed
//   limit           : number of stalled ACCESS cycles allowed
//   expired         : this enabled cycle is the limit-th stalled one
// ----------------------------------------------------------------------------
module analog_apb_timeout_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flag the limit-th stall during that cycle itself, so the initiator
  // leaves ACCESS exactly after `limit` stalled cycles.
  assign expired = enable && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/analog_apb_initiator.sv
// ----------------------------------------------------------------------------
// analog_apb_initiator
// Single-beat APB requester toward the analog status/control register slaves.
// A command is accepted in IDLE, driven through SETUP and ACCESS, and its
// response is held in RESP until the local controller consumes it.
//
// Ports
//   clk_in, reset_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready                  : command handshake (ready only in IDLE)
//   req_addr/req_write/req_wdata/req_strb: command fields
//   rsp_valid/rsp_ready                  : response handshake
//   rsp_rdata/rsp_err/rsp_timeout        : held response
//   PADDR/PWDATA/PWRITE/PSTRB/PSEL/PENABLE : APB request
//   PRDATA/PREADY/PSLVERR                : APB completion
//
// Build option
//   APB_INIT_TIMEOUT_EN : when defined, an ACCESS phase stalled for
//                         TIMEOUT_CYCLES cycles is aborted with rsp_err and
//                         rsp_timeout set. Otherwise ACCESS waits forever.
// ----------------------------------------------------------------------------
module analog_apb_initiator
  import analog_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic                    PWRITE,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  apb_state_e     state, state_next;
  apb_rsp_flags_t rsp_flags;
  logic           accept;
  logic           complete;
  logic           timed_out;

  assign accept   = (state == ST_IDLE) && req_valid;
  // PREADY (and with it PSLVERR) only matters in ACCESS.
  assign complete = (state == ST_ACCESS) && PREADY;

`ifdef APB_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  analog_apb_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .clear   (state == ST_SETUP),
    // A PREADY in the limit cycle keeps enable low, so completion wins.
    .enable  ((state == ST_ACCESS) && !PREADY),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (timed_out)
  );
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
`endif

  // NOTE: state is the only flop here; everything decoded from it is
  // combinational, so req_ready has no path from req_valid and PSEL/PENABLE
  // fall the instant reset_n asserts.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        PSEL       = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timed_out) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are loaded only on acceptance, so they stay put through
  // SETUP/ACCESS and keep showing the last transfer while idle.
  // NOTE: these are plain registers, not a memory, so they take the reset
  // value like any other flop; <= keeps every capture on the same edge.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      rsp_rdata <= '0;
      rsp_flags <= '0;
    end else begin
      if (accept) begin
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
        PWRITE <= req_write;
        PSTRB  <= req_write ? req_strb : '0;
      end
      if (complete) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_flags <= '{err: PSLVERR, timeout: 1'b0};
      end else if (timed_out) begin
        rsp_rdata <= '0;
        rsp_flags <= '{err: 1'b1, timeout: 1'b1};
      end
    end
  end

  assign rsp_err     = rsp_flags.err;
  assign rsp_timeout = rsp_flags.timeout;

endmodule

// File: tb/tb_analog_apb_initiator.sv
// ----------------------------------------------------------------------------
// tb_analog_apb_initiator
// Directed bench for analog_apb_initiator. Inputs are driven and outputs are
// sampled on the falling clock edge. The slave side is played by do_xfer,
// which raises PREADY after a given number of wait cycles.
// With APB_INIT_TIMEOUT_EN defined the watchdog scenarios run (limit 8);
// otherwise a long stall is shown to complete without a timeout.
// ----------------------------------------------------------------------------
module tb_analog_apb_initiator;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [15:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic        PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  // Observations gathered by do_xfer.
  int obs_lat;
  int obs_access;
  int obs_unstable;
  logic obs_setup_ok;

  analog_apb_initiator #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSTRB       (PSTRB),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input logic ok, input string msg);
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Issue one command from IDLE and act as the slave. Call right after a
  // falling edge with the DUT idle. obs_lat is the number of falling edges
  // from acceptance until rsp_valid is seen (-1 if never within 40).
  task automatic do_xfer(input logic [15:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int waits, input logic [31:0] rdata,
                         input logic slverr);
    logic [52:0] snap;
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    req_wdata = wdata; req_strb = strb;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
    obs_lat = -1; obs_access = 0; obs_unstable = 0; obs_setup_ok = 1'b0;
    snap = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        req_valid    = 1'b0;
        obs_setup_ok = PSEL && !PENABLE;
        snap         = {PADDR, PWDATA, PSTRB, PWRITE};
      end
      if (rsp_valid) begin
        PREADY = 1'b0; PSLVERR = 1'b0; obs_lat = k;
        break;
      end
      if (PSEL && PENABLE) obs_access++;
      if (PSEL && ({PADDR, PWDATA, PSTRB, PWRITE} !== snap)) obs_unstable++;
      if (k == 2 + waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk_in);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    check({PSEL, PENABLE, rsp_valid} === 3'b000,
          $sformatf("reset_hold_ctrl: got %b want 000", {PSEL, PENABLE, rsp_valid}));
    reset_n = 1'b1;
    @(negedge clk_in);
    check({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} === 6'b0,
          $sformatf("reset_flags: got %b want 000000",
                    {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}));
    check({PADDR, PWDATA, PSTRB, rsp_rdata} === 84'h0,
          $sformatf("reset_data: PADDR %h PWDATA %h PSTRB %h rdata %h want 0",
                    PADDR, PWDATA, PSTRB, rsp_rdata));
    check(req_ready === 1'b1, $sformatf("reset_req_ready: got %b want 1", req_ready));
  endtask

  task automatic test_read_wait();
    do_xfer(16'h0004, 1'b0, 32'h1111_2222, 4'hF, 1, 32'hA5A5_1234, 1'b0);
    check(obs_lat === 4, $sformatf("read_latency: got %0d want 4", obs_lat));
    check(obs_setup_ok === 1'b1, $sformatf("read_setup_phase: got %b want 1", obs_setup_ok));
    check(obs_access === 2, $sformatf("read_access_cycles: got %0d want 2", obs_access));
    check(rsp_rdata === 32'hA5A5_1234, $sformatf("read_rdata: got %h want a5a51234", rsp_rdata));
    check({rsp_err, rsp_timeout} === 2'b00,
          $sformatf("read_err: got %b want 00", {rsp_err, rsp_timeout}));
    check({PSTRB, PADDR} === {4'h0, 16'h0004},
          $sformatf("read_pstrb_paddr: got %h/%h want 0/0004", PSTRB, PADDR));
    check({PSEL, PENABLE} === 2'b00,
          $sformatf("read_resp_psel: got %b want 00", {PSEL, PENABLE}));
    consume();
    check({rsp_valid, req_ready} === 2'b01,
          $sformatf("read_after_consume: got %b want 01", {rsp_valid, req_ready}));
  endtask

  task automatic test_write_err();
    do_xfer(16'h0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 1'b1);
    check(obs_lat === 4, $sformatf("wr_latency: got %0d want 4", obs_lat));
    check(rsp_err === 1'b1, $sformatf("wr_err: got %b want 1", rsp_err));
    check(rsp_rdata === 32'h0, $sformatf("wr_rdata: got %h want 0", rsp_rdata));
    check(obs_unstable === 0, $sformatf("wr_bus_stable: got %0d changes want 0", obs_unstable));
    check({PWDATA, PSTRB, PWRITE} === {32'hDEAD_BEEF, 4'hF, 1'b1},
          $sformatf("wr_bus_hold: got %h/%h/%b want deadbeef/f/1", PWDATA, PSTRB, PWRITE));
    consume();
  endtask

  task automatic test_unmapped_then_ok();
    do_xfer(16'h0010, 1'b0, 32'h0, 4'h0, 0, 32'hBAD0_BAD0, 1'b1);
    check(obs_lat === 3, $sformatf("unmapped_latency: got %0d want 3", obs_lat));
    check({rsp_err, rsp_timeout} === 2'b10,
          $sformatf("unmapped_err: got %b want 10", {rsp_err, rsp_timeout}));
    consume();
    do_xfer(16'h000C, 1'b0, 32'h0, 4'h0, 2, 32'h0000_C0DE, 1'b0);
    check(obs_lat === 5, $sformatf("status3_latency: got %0d want 5", obs_lat));
    check({rsp_err, rsp_rdata} === {1'b0, 32'h0000_C0DE},
          $sformatf("status3_rsp: got err %b data %h want 0/0000c0de", rsp_err, rsp_rdata));
    consume();
  endtask

  task automatic test_timeout();
`ifdef APB_INIT_TIMEOUT_EN
    do_xfer(16'h0020, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
    check(obs_lat === 10, $sformatf("to_latency: got %0d want 10", obs_lat));
    check(obs_access === 8, $sformatf("to_access_cycles: got %0d want 8", obs_access));
    check({rsp_err, rsp_timeout, PSEL, PENABLE} === 4'b1100,
          $sformatf("to_flags: got %b want 1100", {rsp_err, rsp_timeout, PSEL, PENABLE}));
    check(rsp_rdata === 32'h0, $sformatf("to_rdata: got %h want 0", rsp_rdata));
    consume();
    do_xfer(16'h0024, 1'b0, 32'h0, 4'h0, 7, 32'h7777_0008, 1'b0);
    check(obs_lat === 10, $sformatf("to_edge_latency: got %0d want 10", obs_lat));
    check({rsp_err, rsp_timeout, rsp_rdata} === {2'b00, 32'h7777_0008},
          $sformatf("to_edge_rsp: got %b/%h want 00/77770008",
                    {rsp_err, rsp_timeout}, rsp_rdata));
    consume();
`else
    do_xfer(16'h0020, 1'b0, 32'h0, 4'h0, 20, 32'h2020_2020, 1'b0);
    check(obs_lat === 23, $sformatf("long_wait_latency: got %0d want 23", obs_lat));
    check({rsp_err, rsp_timeout, rsp_rdata} === {2'b00, 32'h2020_2020},
          $sformatf("long_wait_rsp: got %b/%h want 00/20202020",
                    {rsp_err, rsp_timeout}, rsp_rdata));
    consume();
`endif
  endtask

  task automatic test_backpressure();
    do_xfer(16'h0008, 1'b0, 32'h0, 4'h0, 0, 32'h0808_0808, 1'b0);
    check(obs_lat === 3, $sformatf("bp_latency: got %0d want 3", obs_lat));
    req_valid = 1'b1; req_addr = 16'h000C; req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check({rsp_valid, req_ready, PSEL} === 3'b100 && rsp_rdata === 32'h0808_0808 &&
            rsp_err === 1'b0,
            $sformatf("bp_hold_%0d: valid/ready/psel %b data %h err %b want 100/08080808/0",
                      i, {rsp_valid, req_ready, PSEL}, rsp_rdata, rsp_err));
    end
    consume();
    check({rsp_valid, req_ready, PSEL} === 3'b010,
          $sformatf("bp_release: got %b want 010", {rsp_valid, req_ready, PSEL}));
    @(negedge clk_in);
    req_valid = 1'b0;
    check({PSEL, PENABLE, PADDR} === {2'b10, 16'h000C},
          $sformatf("bp_next_setup: got %b/%h want 10/000c", {PSEL, PENABLE}, PADDR));
    // PREADY raised during SETUP must be ignored there.
    PREADY = 1'b1; PRDATA = 32'h0C0C_0C0C; PSLVERR = 1'b0;
    @(negedge clk_in);
    check({PSEL, PENABLE, rsp_valid} === 3'b110,
          $sformatf("bp_next_access: got %b want 110", {PSEL, PENABLE, rsp_valid}));
    @(negedge clk_in);
    PREADY = 1'b0;
    check({rsp_valid, rsp_rdata} === {1'b1, 32'h0C0C_0C0C},
          $sformatf("bp_next_rsp: got %b/%h want 1/0c0c0c0c", rsp_valid, rsp_rdata));
    consume();
  endtask

  task automatic test_back_to_back();
    int setups = 0;
    int resps  = 0;
    int bad    = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030;
    req_wdata = 32'h5555_AAAA; req_strb = 4'h3;
    rsp_ready = 1'b1; PREADY = 1'b1; PRDATA = 32'hFFFF_FFFF; PSLVERR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      if (PSEL && !PENABLE) setups++;
      if (rsp_valid) begin
        resps++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) bad++;
      end
    end
    req_valid = 1'b0;
    @(negedge clk_in);
    rsp_ready = 1'b0; PREADY = 1'b0;
    check(setups === 3 && resps === 3,
          $sformatf("b2b_rate: setups %0d resps %0d want 3/3", setups, resps));
    check(bad === 0, $sformatf("b2b_write_rsp: got %0d bad want 0", bad));
    check({req_ready, PSEL} === 2'b10,
          $sformatf("b2b_idle: got %b want 10", {req_ready, PSEL}));
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_addr = 16'h0004; req_write = 1'b0;
    PREADY = 1'b0;
    @(negedge clk_in);
    req_valid = 1'b0;
    @(negedge clk_in);
    check({PSEL, PENABLE} === 2'b11,
          $sformatf("rst_mid_in_access: got %b want 11", {PSEL, PENABLE}));
    #2 reset_n = 1'b0;
    #1;
    check({PSEL, PENABLE, rsp_valid, req_ready} === 4'b0001,
          $sformatf("rst_mid_async: got %b want 0001", {PSEL, PENABLE, rsp_valid, req_ready}));
    check(PADDR === 16'h0, $sformatf("rst_mid_paddr: got %h want 0000", PADDR));
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    do_xfer(16'h000C, 1'b0, 32'h0, 4'h0, 1, 32'h0000_00C3, 1'b0);
    check(obs_lat === 4 && rsp_rdata === 32'h0000_00C3 && rsp_err === 1'b0,
          $sformatf("rst_mid_recover: lat %0d data %h err %b want 4/000000c3/0",
                    obs_lat, rsp_rdata, rsp_err));
    consume();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_read_wait();
    test_write_err();
    test_unmapped_then_ok();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
